// File: rtl/axis_sample_fifo.sv
// axis_sample_fifo: buffers signed ADC samples and presents them as an AXI4-Stream master.
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   enable            gates adc_valid (no write, no drop accounting when low)
//   flush             synchronous clear of FIFO contents and frame counter
//   adc_valid/data    one-cycle sample strobe from a source without backpressure
//   m_axis_t*         first-word fall-through stream output, tlast every FRAME_LEN words
//   fill_level        entries currently stored (0..DEPTH)
//   overflow          sticky flag, set whenever a sample is dropped
//   overflow_clr      clears overflow and drop_count
//   drop_count        saturating count of dropped samples
module axis_sample_fifo #(
    parameter int DATA_WIDTH     = 24,
    parameter int DEPTH          = 16,
    parameter int FRAME_LEN      = 8,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      flush,
    input  logic                      adc_valid,
    input  logic [DATA_WIDTH-1:0]     adc_data,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [$clog2(DEPTH):0]    fill_level,
    output logic                      overflow,
    input  logic                      overflow_clr,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FRAME_LEN + 1);

    logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]               count_q, count_d;
    logic [FW-1:0]             frame_q, frame_d;
    logic                      overflow_q, overflow_d;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
    logic                      full, empty, accept, wr_en, drop, hs, last;

    always_comb begin
        full       = count_q == (AW+1)'(DEPTH);
        empty      = count_q == '0;
        // A sample arriving during flush is discarded silently, never counted as a drop.
        accept     = enable & adc_valid & ~flush;
        // Fullness is judged before any same-cycle read, so a full FIFO drops even while draining.
        wr_en      = accept & ~full;
        drop       = accept & full;
        hs         = ~empty & m_axis_tready;
        last       = ~empty & (frame_q == FW'(FRAME_LEN - 1));
        wr_ptr_d   = flush ? '0 : wr_ptr_q + AW'(wr_en);
        rd_ptr_d   = flush ? '0 : rd_ptr_q + AW'(hs);
        count_d    = flush ? '0 : count_q + (AW+1)'(wr_en) - (AW+1)'(hs);
        frame_d    = flush ? '0 : !hs ? frame_q : last ? '0 : frame_q + FW'(1);
        // A drop in the same cycle as overflow_clr wins: the counter restarts at one.
        overflow_d = drop | (overflow_q & ~overflow_clr);
        drop_d     = drop ? (overflow_clr ? DROP_CNT_WIDTH'(1) : &drop_q ? drop_q : drop_q + DROP_CNT_WIDTH'(1))
                          : overflow_clr ? '0 : drop_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            frame_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            frame_q    <= frame_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Storage is deliberately not reset; tdata is only meaningful while tvalid is high.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) mem_q[wr_ptr_q] <= adc_data;
    end

    assign m_axis_tvalid = ~empty;
    assign m_axis_tdata  = mem_q[rd_ptr_q];
    assign m_axis_tlast  = last;
    assign fill_level    = count_q;
    assign overflow      = overflow_q;
    assign drop_count    = drop_q;
endmodule

// File: tb/tb_axis_sample_fifo.sv
// tb_axis_sample_fifo: table-driven and scoreboard-checked bench for axis_sample_fifo.
module tb_axis_sample_fifo;
    localparam int FL = 8;
    localparam int DP = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, enable = 1'b1, flush = 1'b0, adc_valid = 1'b0, tready = 1'b0, overflow_clr = 1'b0;
    logic [23:0] adc_data = '0;
    logic        tvalid, tlast, overflow;
    logic [23:0] tdata;
    logic [4:0]  fill_level;
    logic [15:0] drop_count;

    axis_sample_fifo #(.DATA_WIDTH(24), .DEPTH(DP), .FRAME_LEN(FL), .DROP_CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .adc_valid(adc_valid), .adc_data(adc_data),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast), .m_axis_tdata(tdata),
        .fill_level(fill_level), .overflow(overflow), .overflow_clr(overflow_clr), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [23:0] d; logic l; } sb_t;
    typedef struct { logic v; logic [23:0] d; logic r; logic ev; logic [23:0] ed; logic el; logic [4:0] ef; } vec_t;

    sb_t         sb[$];
    int          fc = 0, hs_cnt = 0, last_cnt = 0;
    logic        m_ov = 1'b0;
    logic [15:0] m_dc = '0;
    int          checks = 0, errors = 0;
    vec_t        tbl[12];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic drive(input logic v, input logic [23:0] d, input logic r, input logic fl = 1'b0,
                         input logic oc = 1'b0, input logic en = 1'b1, input logic rs = 1'b1);
        rst_n = rs; enable = en; flush = fl; adc_valid = v; adc_data = d; tready = r; overflow_clr = oc;
    endtask

    task automatic model_check();
        chk("tvalid", 32'(tvalid), 32'(sb.size() != 0));
        chk("fill_level", 32'(fill_level), 32'(sb.size()));
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("drop_count", 32'(drop_count), 32'(m_dc));
        if (sb.size() != 0) begin
            chk("tdata", 32'(tdata), 32'(sb[0].d));
            chk("tlast", 32'(tlast), 32'(sb[0].l));
        end else chk("tlast_empty", 32'(tlast), 32'(0));
    endtask

    task automatic model_update();
        sb_t s;
        bit full, hs, dr, wr;
        if (!rst_n) begin
            sb.delete(); fc = 0; m_ov = 1'b0; m_dc = '0;
        end else if (flush) begin
            sb.delete(); fc = 0;
            if (overflow_clr) begin m_ov = 1'b0; m_dc = '0; end
        end else begin
            full = sb.size() == DP;
            hs   = sb.size() != 0 && tready;
            dr   = enable && adc_valid && full;
            wr   = enable && adc_valid && !full;
            if (hs) begin
                s = sb.pop_front();
                hs_cnt++;
                if (s.l) last_cnt++;
                fc = s.l ? 0 : fc + 1;
            end
            if (overflow_clr) begin m_ov = 1'b0; m_dc = '0; end
            if (dr) begin
                m_ov = 1'b1;
                if (m_dc != 16'hFFFF) m_dc++;
            end
            if (wr) sb.push_back('{adc_data, ((fc + sb.size()) % FL) == FL - 1});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [23:0] d, input logic r, input logic fl = 1'b0,
                        input logic oc = 1'b0, input logic en = 1'b1, input logic rs = 1'b1);
        drive(v, d, r, fl, oc, en, rs);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 10; i++)
            tbl[i] = '{1'b1, 24'(i + 1), 1'b1, i > 0, 24'(i), i == 8, 5'(i > 0)};
        tbl[10] = '{1'b0, 24'h0, 1'b1, 1'b1, 24'd10, 1'b0, 5'd1};
        tbl[11] = '{1'b0, 24'h0, 1'b1, 1'b0, 24'd0, 1'b0, 5'd0};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].r);
            #3;
            chk("t1_valid", 32'(tvalid), 32'(tbl[i].ev));
            chk("t1_fill", 32'(fill_level), 32'(tbl[i].ef));
            chk("t1_last", 32'(tlast), 32'(tbl[i].el));
            if (tbl[i].ev) chk("t1_data", 32'(tdata), 32'(tbl[i].ed));
            tick();
        end
        chk("t1_hs_cnt", 32'(hs_cnt), 32'd10);
        chk("t1_last_cnt", 32'(last_cnt), 32'd1);

        last_cnt = 0;
        for (int i = 0; i < 6; i++) step(1'b1, 24'h20 + 24'(i), 1'b1);
        step(1'b0, 24'h0, 1'b1);
        chk("t1_frame_resume", 32'(last_cnt), 32'd1);

        step(1'b0, 24'h0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 24'h100 + 24'(i), 1'b0);
        chk("ovf_fill", 32'(fill_level), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drops", 32'(drop_count), 32'd4);
        hs_cnt = 0; last_cnt = 0;
        for (int i = 0; i < 17; i++) step(1'b0, 24'h0, 1'b1);
        chk("ovf_drain_hs", 32'(hs_cnt), 32'd16);
        chk("ovf_drain_last", 32'(last_cnt), 32'd2);

        for (int i = 0; i < 16; i++) step(1'b1, 24'h200 + 24'(i), 1'b0);
        step(1'b1, 24'h2FF, 1'b1);
        chk("fullrd_fill", 32'(fill_level), 32'd15);
        chk("fullrd_drops", 32'(drop_count), 32'd5);

        step(1'b0, 24'h0, 1'b0, 1'b1);
        step(1'b1, 24'h800000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(i < 3, 24'h300 + 24'(i), 1'b0);
            chk("bp_data", 32'(tdata), 32'h800000);
            chk("bp_valid", 32'(tvalid), 32'd1);
        end
        chk("bp_fill", 32'(fill_level), 32'd4);

        step(1'b0, 24'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 24'h400 + 24'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 24'h0, 1'b1);
        chk("fl_fill_before", 32'(fill_level), 32'd5);
        step(1'b0, 24'h0, 1'b0, 1'b1);
        chk("fl_valid", 32'(tvalid), 32'd0);
        chk("fl_fill", 32'(fill_level), 32'd0);
        chk("fl_ovf_kept", 32'(overflow), 32'd1);
        last_cnt = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 24'h500 + 24'(i), 1'b1);
        step(1'b0, 24'h0, 1'b1);
        chk("fl_frame_last", 32'(last_cnt), 32'd1);

        step(1'b1, 24'h600, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("en_low_fill", 32'(fill_level), 32'd0);

        for (int i = 0; i < 16; i++) step(1'b1, 24'h700 + 24'(i), 1'b0);
        step(1'b1, 24'h7FF, 1'b0, 1'b0, 1'b1);
        chk("clr_drop_ovf", 32'(overflow), 32'd1);
        chk("clr_drop_cnt", 32'(drop_count), 32'd1);
        step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_cnt", 32'(drop_count), 32'd0);

        step(1'b1, 24'h7FE, 1'b0);
        step(1'b1, 24'h900, 1'b1);
        step(1'b1, 24'h901, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_valid", 32'(tvalid), 32'd0);
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_cnt", 32'(drop_count), 32'd0);
        chk("rst_last", 32'(tlast), 32'd0);
        step(1'b0, 24'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_sample_fifo.md
Name: axis_sample_fifo

Overview:
- Buffers raw signed 24-bit ADC samples and presents them as an AXI4-Stream master.
- Sits directly upstream of the AXI4 read-data bridge, which pulls samples on s_axis and returns them to the processor as sign-extended 32-bit words.
- Absorbs bus latency between bursts, asserts tlast every FRAME_LEN transferred samples, and counts samples dropped on overflow.

Parameters:
- DATA_WIDTH, 24, sample / tdata width.
- DEPTH, 16, FIFO entries; must be a power of 2, ≥ 4.
- FRAME_LEN, 8, samples per frame; tlast accompanies the last one; range 1..256.
- DROP_CNT_WIDTH, 16, width of the dropped-sample counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- enable  in  1  when low, adc_valid is ignored (no write, no drop count).
- flush  in  1  synchronous clear of FIFO contents and frame counter.
- adc_valid  in  1  one-cycle strobe per sample; source has no backpressure.
- adc_data  in  DATA_WIDTH  signed sample.
- m_axis_tvalid  out  1  FIFO not empty.
- m_axis_tready  in  1  downstream accept.
- m_axis_tlast  out  1  current word closes a frame.
- m_axis_tdata  out  DATA_WIDTH  head-of-FIFO sample.
- fill_level  out  $clog2(DEPTH)+1  entries currently stored.
- overflow  out  1  sticky; set on any drop.
- overflow_clr  in  1  clears overflow and drop_count.
- drop_count  out  DROP_CNT_WIDTH  samples dropped; saturates at all-ones.

Behaviour:
- Reset is rst_n, synchronous, active-low; clock is clk.
- Reset state: pointers 0, fill_level 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata don't-care (memory not reset), overflow 0, drop_count 0, frame counter 0.
- Write: wr_en = enable & adc_valid & !full.
  - On wr_en, store adc_data at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
- Drop: enable & adc_valid & full.
  - The sample is discarded and overflow is set.
  - drop_count increments, holding at max.
  - Full is evaluated before any same-cycle read, so a write into a full FIFO drops even if a read occurs that cycle.
- Read (first-word fall-through):
  - m_axis_tvalid = !empty; m_axis_tdata = mem[rd_ptr].
  - Handshake = tvalid & tready. On handshake, rd_ptr increments and wraps.
- Latency: a sample written into an empty FIFO at clock edge N is visible with tvalid=1 in the cycle following edge N (1 cycle).
- Empty: tvalid=0, and tready is ignored. A same-cycle write into an empty FIFO is not readable until the next cycle.
- fill_level: +1 on write only, −1 on handshake only, unchanged when both or neither occur. Range 0..DEPTH; full ⇔ fill_level==DEPTH.
- Frame counter (0..FRAME_LEN−1) counts handshakes only.
  - m_axis_tlast = tvalid & (frame_cnt==FRAME_LEN−1).
  - A handshake with tlast wraps the counter to 0.
  - Drops do not affect the frame counter. FRAME_LEN=1 ⇒ tlast on every word.
- tdata, tlast and tvalid are stable while tvalid & !tready. No new write changes the head entry.
- flush (priority below reset, above all else):
  - Next cycle: pointers 0, fill_level 0, tvalid 0, frame_cnt 0.
  - A sample arriving in the flush cycle is discarded and not counted as a drop.
  - overflow and drop_count are retained.
- overflow_clr: overflow←0 and drop_count←0. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- enable deassertion does not stop draining; buffered samples remain readable.

Test Plan:
- Fill and drain, DEPTH=16, FRAME_LEN=8, tready=1.
  - Stimulus: write 0x000001..0x00000A on consecutive cycles.
  - Required: ten handshakes in order, tlast only on 0x000008, fill_level never above 1. The frame counter sits at 2 afterwards.
- Overflow.
  - Stimulus: tready=0, write 20 samples.
  - Required: fill_level=16, overflow=1, drop_count=4.
  - Then drain: the exact first 16 samples appear, with tlast on the 8th and 16th.
- Backpressure stability.
  - Stimulus: write 0x800000; hold tready=0 for 5 cycles while writing 3 more.
  - Required: tdata stays 0x800000, tvalid=1 throughout, fill_level=4.
- Full with simultaneous read.
  - Stimulus: FIFO full, tready=1, adc_valid=1 in the same cycle.
  - Required: one handshake, sample dropped, drop_count +1, fill_level=15.
- Flush mid-frame.
  - Stimulus: after 3 handshakes plus 5 buffered entries, pulse flush.
  - Required: tvalid=0 and fill_level=0 next cycle. Overflow is retained. The next 8 written samples give tlast on the 8th.
- Reset and clear interaction.
  - Stimulus: overflow_clr concurrent with a drop.
  - Required: overflow=1, drop_count=1.
  - Stimulus: rst_n low for 1 cycle mid-stream.
  - Required: all outputs at reset values the following cycle.
